// File: rtl/uart_8bit_tx_if.sv
// Request/serial-line bundle for uart_8bit_tx: byte request in, serial line and status out.
// Handshake: a byte transfers on the rising edge where enviar (valid) and listo (ready) are both 1.
interface uart_8bit_tx_if;
  logic [7:0] Tx_reg;
  logic       enviar;
  logic       Tx_data;
  logic       listo;
  logic [2:0] estado;

  modport master (
    output Tx_reg,
    output enviar,
    input  Tx_data,
    input  listo,
    input  estado
  );

  modport slave (
    input  Tx_reg,
    input  enviar,
    output Tx_data,
    output listo,
    output estado
  );
endinterface

// File: rtl/uart_8bit_tx.sv
// 8-bit serial transmitter: low start, high start, 8 data bits MSB first, stop, optional idle gap.
// Macro UART_TX_GAP_EN enables the pausa state and the GAP_CLKS idle-high gap after the stop bit.
module uart_8bit_tx #(
  parameter int BIT_CLKS = 82,
  parameter int GAP_CLKS = 250
) (
  input  logic           clk,
  input  logic           reset,
  uart_8bit_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    ESPERA = 3'b000,
    START0 = 3'b001,
    START1 = 3'b010,
    DATOS  = 3'b011,
    STOP   = 3'b100,
    PAUSA  = 3'b101
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(BIT_CLKS - 1);

  if (BIT_CLKS < 2 || BIT_CLKS > 111) begin : g_bad_bit_clks
    $error("uart_8bit_tx: BIT_CLKS out of range 2..111");
  end
  if (GAP_CLKS < 1 || GAP_CLKS > 4095) begin : g_bad_gap_clks
    $error("uart_8bit_tx: GAP_CLKS out of range 1..4095");
  end

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic       r_tx;
  logic       r_listo;
`ifdef UART_TX_GAP_EN
  localparam logic [11:0] LP_GAP_LAST = 12'(GAP_CLKS - 1);
  logic [11:0] r_gap;
`endif

  logic w_bit_end;
  assign w_bit_end = (r_cnt == LP_CNT_LAST);

  // Tx_data and listo are assigned alongside each transition so they stay glitch-free flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ESPERA;
      r_cnt   <= 8'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_listo <= 1'b1;
`ifdef UART_TX_GAP_EN
      r_gap   <= 12'd0;
`endif
    end else begin
      case (r_state)
        ESPERA: begin
          r_tx    <= 1'b1;
          r_listo <= 1'b1;
          if (bus.enviar) begin
            r_shift <= bus.Tx_reg;
            r_cnt   <= 8'd0;
            r_state <= START0;
            r_tx    <= 1'b0;
            r_listo <= 1'b0;
          end
        end
        START0: begin
          if (w_bit_end) begin
            r_cnt   <= 8'd0;
            r_state <= START1;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        START1: begin
          if (w_bit_end) begin
            r_cnt   <= 8'd0;
            r_idx   <= 3'd0;
            r_state <= DATOS;
            r_tx    <= r_shift[7];
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DATOS: begin
          if (w_bit_end) begin
            r_cnt   <= 8'd0;
            r_shift <= {r_shift[6:0], 1'b0};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx <= r_shift[6];
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= 8'd0;
`ifdef UART_TX_GAP_EN
            r_gap   <= 12'd0;
            r_state <= PAUSA;
`else
            r_state <= ESPERA;
            r_listo <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
`ifdef UART_TX_GAP_EN
        PAUSA: begin
          r_tx <= 1'b1;
          if (r_gap == LP_GAP_LAST) begin
            r_gap   <= 12'd0;
            r_state <= ESPERA;
            r_listo <= 1'b1;
          end else begin
            r_gap <= r_gap + 12'd1;
          end
        end
`endif
        default: begin
          r_state <= ESPERA;
          r_cnt   <= 8'd0;
          r_tx    <= 1'b1;
          r_listo <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Tx_data = r_tx;
  assign bus.listo   = r_listo;
  assign bus.estado  = r_state;

endmodule
